exception_unit: RTL and testbench
=================================

Name: exception_unit

Overview:
- Parametrised pipeline exception and execution-lock controller for the RV32I core.
- Collects per-stage exception codes and lock requests from NUM_SRC pipeline stages.
- Selects the oldest-stage exception by fixed priority, then latches cause, faulting PC and source index.
- Runs a RUN/HALT/FLUSH state machine: halts the core on environment break until resumed, and holds a core reset pulse for RESET_HOLD cycles on fatal exceptions.

Parameters:
- NUM_SRC, 3: number of exception/lock sources. Index 0 is the earliest stage and has the highest priority.
- EXC_LEN, 4: exception code width.
- XLEN, 32: PC width.
- EXC_OK, 0: "no exception" code.
- EXC_BREAK, 1: environment-break code. Halts the core; does not reset it.
- RESET_HOLD, 2: core reset pulse length in cycles. Legal values are 1 or more.
- SRC_W, 2: width of src_out. Must be at least max(1, clog2(NUM_SRC)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- exc_in  in  NUM_SRC*EXC_LEN  per-source exception code; source i occupies bits [i*EXC_LEN +: EXC_LEN].
- pc_in  in  NUM_SRC*XLEN  PC associated with each source; source i occupies bits [i*XLEN +: XLEN].
- lock_req_in  in  NUM_SRC  per-stage execution-lock request.
- resume_in  in  1  resume request from HALT.
- exec_lock_out  out  1  freeze all architectural state updates.
- core_rst_out  out  1  reset to the pipeline stages and register file.
- cause_out  out  EXC_LEN  latched exception cause.
- epc_out  out  XLEN  latched faulting PC.
- src_out  out  SRC_W  latched source index.
- trap_valid_out  out  1  one-cycle pulse on each new capture.
- halted_out  out  1  high while in HALT.

Behaviour:
- Reset (rst=1 at an edge):
  - state ← RUN; hold counter ← 0.
  - cause_out ← EXC_OK; epc_out ← 0; src_out ← 0; trap_valid_out ← 0.
  - core_rst_out = rst OR (state==FLUSH), combinational, so it is high during any cycle rst is high.
  - rst overrides everything, including a reset that arrives mid-HALT or mid-FLUSH.
- Selection (combinational):
  - hit = any exc_in[i] ≠ EXC_OK.
  - sel = lowest index i with a non-OK code.
  - Each source is compared against its own code slice; no cross-source aliasing.
- RUN:
  - exec_lock_out = (OR of lock_req_in) OR hit, combinational, same cycle.
  - If hit at an edge, latch cause_out ← exc_in[sel], epc_out ← pc_in[sel], src_out ← sel, and trap_valid_out ← 1 for exactly the next cycle.
  - Next state: HALT if the code is EXC_BREAK. Otherwise FLUSH, with counter ← RESET_HOLD.
  - resume_in is ignored in RUN.
- HALT:
  - exec_lock_out = 1; halted_out = 1; core_rst_out = 0.
  - All exc_in and lock_req_in values are ignored; latched outputs are held.
  - resume_in = 1 at an edge → RUN next cycle. resume_in takes precedence over any simultaneous exc_in (that exc_in is dropped).
- FLUSH:
  - core_rst_out = 1; exec_lock_out = 1; exc_in ignored.
  - Counter decrements each cycle. When it reaches 0, go to RUN; core_rst_out stays high exactly RESET_HOLD cycles.
- Latched fields:
  - cause_out, epc_out and src_out are sticky until the next capture or rst.
  - They are not cleared on RUN entry, so software and debug can read them after recovery.
- trap_valid_out: registered; low in every cycle except the one following a capture.
- No back-to-back capture: a capture only occurs in RUN, and both HALT and FLUSH last at least 1 cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles with exc_in of src0 = 3 → core_rst_out=1 in both cycles; after release state is RUN, cause_out=0, epc_out=0, trap_valid_out=0, exec_lock_out=0.
- Priority: src1 code 3 at pc 0x104 and src2 code 5 at pc 0x108 in the same cycle → cause_out=3, epc_out=0x104, src_out=1; trap_valid_out high 1 cycle; core_rst_out high exactly 2 cycles, then RUN.
- Break: src2 code 1 at pc 0x200 → halted_out=1, exec_lock_out=1. Inject src0 code 3 during 10 HALT cycles → ignored, cause_out stays 1. Pulse resume_in → RUN next cycle; cause_out still 1.
- Lock passthrough: no exceptions, lock_req_in=3'b010 → exec_lock_out=1 in the same cycle and 0 once cleared; trap_valid_out never pulses.
- Mid-flush reset: RESET_HOLD=4, fatal src0 code 2, assert rst after 1 FLUSH cycle → RUN after rst; cause_out=0, epc_out=0; core_rst_out falls when rst deasserts.
- Scaling: NUM_SRC=5, SRC_W=3, RESET_HOLD=1, only src4 code 6 at pc 0x40 → src_out=4, epc_out=0x40, core_rst_out high exactly 1 cycle.

Source files
------------

// File: rtl/exception_unit_if.sv
// exception_unit_if: pipeline-to-exception-unit bundle; master = pipeline side (codes, pcs, lock, resume in), slave = unit side (lock, core reset, trap record out)
interface exception_unit_if #(
  parameter int NUM_SRC = 3,
  parameter int EXC_LEN = 4,
  parameter int XLEN = 32,
  parameter int SRC_W = 2
);
  logic [NUM_SRC*EXC_LEN-1:0] exc_in;
  logic [NUM_SRC*XLEN-1:0] pc_in;
  logic [NUM_SRC-1:0] lock_req_in;
  logic resume_in;
  logic exec_lock_out;
  logic core_rst_out;
  logic [EXC_LEN-1:0] cause_out;
  logic [XLEN-1:0] epc_out;
  logic [SRC_W-1:0] src_out;
  logic trap_valid_out;
  logic halted_out;
  modport master (
    output exc_in, pc_in, lock_req_in, resume_in,
    input exec_lock_out, core_rst_out, cause_out, epc_out, src_out, trap_valid_out, halted_out
  );
  modport slave (
    input exc_in, pc_in, lock_req_in, resume_in,
    output exec_lock_out, core_rst_out, cause_out, epc_out, src_out, trap_valid_out, halted_out
  );
endinterface

// File: rtl/exception_unit.sv
// exception_unit: priority exception capture with RUN/HALT/FLUSH control; ports clk, rst, bus (exception_unit_if.slave: exc/pc/lock/resume in, lock/core reset/cause/epc/src/trap/halted out)
module exception_unit #(
  parameter int NUM_SRC = 3,
  parameter int EXC_LEN = 4,
  parameter int XLEN = 32,
  parameter int EXC_OK = 0,
  parameter int EXC_BREAK = 1,
  parameter int RESET_HOLD = 2,
  parameter int SRC_W = 2
) (
  input logic clk,
  input logic rst,
  exception_unit_if.slave bus
);
  localparam int CNT_W = $clog2(RESET_HOLD + 1);
  typedef enum logic [1:0] {RUN, HALT, FLUSH} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic hit, capture;
  logic [SRC_W-1:0] sel;
  logic [EXC_LEN-1:0] sel_code;
  logic [XLEN-1:0] sel_pc;
  always_comb begin
    hit = 1'b0;
    sel = '0;
    sel_code = EXC_LEN'(EXC_OK);
    sel_pc = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (bus.exc_in[i*EXC_LEN +: EXC_LEN] != EXC_LEN'(EXC_OK)) begin
        hit = 1'b1;
        sel = SRC_W'(i);
        sel_code = bus.exc_in[i*EXC_LEN +: EXC_LEN];
        sel_pc = bus.pc_in[i*XLEN +: XLEN];
      end
  end
  assign capture = (state == RUN) && hit;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      RUN:
        if (hit) begin
          state_n = (sel_code == EXC_LEN'(EXC_BREAK)) ? HALT : FLUSH;
          cnt_n = CNT_W'(RESET_HOLD);
        end
      HALT: state_n = bus.resume_in ? RUN : HALT;
      FLUSH: begin
        cnt_n = cnt - 1'b1;
        state_n = (cnt <= CNT_W'(1)) ? RUN : FLUSH;
      end
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      bus.cause_out <= EXC_LEN'(EXC_OK);
      bus.epc_out <= '0;
      bus.src_out <= '0;
      bus.trap_valid_out <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.trap_valid_out <= capture;
      if (capture) begin
        bus.cause_out <= sel_code;
        bus.epc_out <= sel_pc;
        bus.src_out <= sel;
      end
    end
  end
  assign bus.exec_lock_out = (state != RUN) || (|bus.lock_req_in) || hit;
  assign bus.core_rst_out = rst || (state == FLUSH);
  assign bus.halted_out = (state == HALT);
endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: randomized and directed checks of exception_unit against a behavioural model
module tb_exception_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  exception_unit_if #(.NUM_SRC(3), .EXC_LEN(4), .XLEN(32), .SRC_W(2)) i0 ();
  exception_unit_if #(.NUM_SRC(3), .EXC_LEN(4), .XLEN(32), .SRC_W(2)) i1 ();
  exception_unit_if #(.NUM_SRC(5), .EXC_LEN(4), .XLEN(32), .SRC_W(3)) i2 ();
  exception_unit #(.NUM_SRC(3), .RESET_HOLD(2), .SRC_W(2)) u0 (.clk(clk), .rst(rst), .bus(i0));
  exception_unit #(.NUM_SRC(3), .RESET_HOLD(4), .SRC_W(2)) u1 (.clk(clk), .rst(rst), .bus(i1));
  exception_unit #(.NUM_SRC(5), .RESET_HOLD(1), .SRC_W(3)) u2 (.clk(clk), .rst(rst), .bus(i2));
  bit m_halt;
  int m_left;
  logic [3:0] m_cause;
  logic [31:0] m_epc;
  logic [1:0] m_src;
  bit m_tv;
  function automatic logic [41:0] obs();
    return {i0.exec_lock_out, i0.core_rst_out, i0.halted_out, i0.trap_valid_out, i0.cause_out, i0.epc_out, i0.src_out};
  endfunction
  function automatic logic [41:0] expv();
    bit any = 1'b0;
    for (int i = 0; i < 3; i++) if (i0.exc_in[i*4 +: 4] != 4'd0) any = 1'b1;
    return {m_halt || m_left > 0 || (|i0.lock_req_in) || any, rst || m_left > 0, m_halt, m_tv, m_cause, m_epc, m_src};
  endfunction
  task automatic model_step();
    int first = -1;
    if (rst) begin
      m_halt = 0; m_left = 0; m_cause = 0; m_epc = 0; m_src = 0; m_tv = 0;
      return;
    end
    m_tv = 0;
    if (m_halt) begin
      if (i0.resume_in) m_halt = 0;
    end else if (m_left > 0) m_left--;
    else begin
      for (int i = 2; i >= 0; i--) if (i0.exc_in[i*4 +: 4] != 4'd0) first = i;
      if (first >= 0) begin
        m_cause = i0.exc_in[first*4 +: 4];
        m_epc = i0.pc_in[first*32 +: 32];
        m_src = 2'(first);
        m_tv = 1;
        if (m_cause == 4'd1) m_halt = 1;
        else m_left = 2;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle_all();
    i0.exc_in = '0; i0.pc_in = '0; i0.lock_req_in = '0; i0.resume_in = 1'b0;
    i1.exc_in = '0; i1.pc_in = '0; i1.lock_req_in = '0; i1.resume_in = 1'b0;
    i2.exc_in = '0; i2.pc_in = '0; i2.lock_req_in = '0; i2.resume_in = 1'b0;
  endtask
  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    i0.exc_in = 12'h003;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (i0.core_rst_out !== 1'b1) begin errors++; $display("FAIL reset_core_rst cycle %0d: got %b want 1", c, i0.core_rst_out); end
      tick();
    end
    rst = 1'b0;
    i0.exc_in = '0;
    #1;
    checks++;
    if (obs() !== {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 2'd0}) begin errors++; $display("FAIL reset_state: got %h want 0", obs()); end
  endtask
  task automatic test_priority();
    int highs = 0;
    i0.exc_in = {4'd5, 4'd3, 4'd0};
    i0.pc_in = {32'h108, 32'h104, 32'h100};
    #1;
    checks++;
    if (i0.exec_lock_out !== 1'b1) begin errors++; $display("FAIL prio_lock: got %b want 1", i0.exec_lock_out); end
    tick();
    i0.exc_in = '0;
    #1;
    checks++;
    if ({i0.cause_out, i0.epc_out, i0.src_out, i0.trap_valid_out} !== {4'd3, 32'h104, 2'd1, 1'b1})
      begin errors++; $display("FAIL prio_capture: got %h/%h/%0d/%b want 3/104/1/1", i0.cause_out, i0.epc_out, i0.src_out, i0.trap_valid_out); end
    for (int c = 0; c < 5; c++) begin
      if (i0.core_rst_out === 1'b1) highs++;
      if (c == 1) begin
        checks++;
        if (i0.trap_valid_out !== 1'b0) begin errors++; $display("FAIL prio_tv_width: got %b want 0", i0.trap_valid_out); end
      end
      tick();
      #1;
    end
    checks++;
    if (highs != 2) begin errors++; $display("FAIL prio_flush_len: got %0d want 2", highs); end
    checks++;
    if ({i0.exec_lock_out, i0.core_rst_out, i0.cause_out} !== {1'b0, 1'b0, 4'd3}) begin errors++; $display("FAIL prio_after: got %b%b/%0d want 00/3", i0.exec_lock_out, i0.core_rst_out, i0.cause_out); end
  endtask
  task automatic test_break();
    i0.exc_in = {4'd1, 4'd0, 4'd0};
    i0.pc_in = {32'h200, 32'h0, 32'h0};
    tick();
    i0.exc_in = 12'h003;
    i0.pc_in = 96'h55;
    #1;
    checks++;
    if ({i0.halted_out, i0.exec_lock_out, i0.cause_out, i0.epc_out, i0.src_out} !== {1'b1, 1'b1, 4'd1, 32'h200, 2'd2})
      begin errors++; $display("FAIL break_enter: got %b%b/%0d/%h/%0d want 11/1/200/2", i0.halted_out, i0.exec_lock_out, i0.cause_out, i0.epc_out, i0.src_out); end
    for (int c = 0; c < 10; c++) tick();
    #1;
    checks++;
    if ({i0.halted_out, i0.cause_out, i0.trap_valid_out, i0.core_rst_out} !== {1'b1, 4'd1, 1'b0, 1'b0})
      begin errors++; $display("FAIL break_hold: got %b/%0d/%b/%b want 1/1/0/0", i0.halted_out, i0.cause_out, i0.trap_valid_out, i0.core_rst_out); end
    i0.resume_in = 1'b1;
    tick();
    i0.resume_in = 1'b0;
    i0.exc_in = '0;
    #1;
    checks++;
    if ({i0.halted_out, i0.exec_lock_out, i0.cause_out, i0.trap_valid_out} !== {1'b0, 1'b0, 4'd1, 1'b0})
      begin errors++; $display("FAIL break_resume: got %b%b/%0d/%b want 00/1/0", i0.halted_out, i0.exec_lock_out, i0.cause_out, i0.trap_valid_out); end
  endtask
  task automatic test_lock();
    i0.lock_req_in = 3'b010;
    #1;
    checks++;
    if (i0.exec_lock_out !== 1'b1) begin errors++; $display("FAIL lock_on: got %b want 1", i0.exec_lock_out); end
    tick();
    i0.lock_req_in = 3'b000;
    #1;
    checks++;
    if ({i0.exec_lock_out, i0.trap_valid_out} !== 2'b00) begin errors++; $display("FAIL lock_off: got %b%b want 00", i0.exec_lock_out, i0.trap_valid_out); end
  endtask
  task automatic test_mid_flush();
    i1.exc_in = 12'h002;
    i1.pc_in = 96'h80;
    tick();
    i1.exc_in = '0;
    #1;
    checks++;
    if ({i1.core_rst_out, i1.trap_valid_out, i1.cause_out} !== {1'b1, 1'b1, 4'd2}) begin errors++; $display("FAIL midflush_enter: got %b%b/%0d want 11/2", i1.core_rst_out, i1.trap_valid_out, i1.cause_out); end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (i1.core_rst_out !== 1'b1) begin errors++; $display("FAIL midflush_rst: got %b want 1", i1.core_rst_out); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({i1.core_rst_out, i1.exec_lock_out, i1.trap_valid_out, i1.cause_out, i1.epc_out} !== {3'b000, 4'd0, 32'd0})
      begin errors++; $display("FAIL midflush_after: got %b%b%b/%0d/%h want 000/0/0", i1.core_rst_out, i1.exec_lock_out, i1.trap_valid_out, i1.cause_out, i1.epc_out); end
  endtask
  task automatic test_scaling();
    int highs = 0;
    i2.exc_in = {4'd6, 16'd0};
    i2.pc_in = {32'h40, 128'd0};
    tick();
    i2.exc_in = '0;
    #1;
    checks++;
    if ({i2.src_out, i2.epc_out, i2.cause_out} !== {3'd4, 32'h40, 4'd6}) begin errors++; $display("FAIL scale_capture: got %0d/%h/%0d want 4/40/6", i2.src_out, i2.epc_out, i2.cause_out); end
    for (int c = 0; c < 4; c++) begin
      if (i2.core_rst_out === 1'b1) highs++;
      tick();
      #1;
    end
    checks++;
    if (highs != 1) begin errors++; $display("FAIL scale_flush_len: got %0d want 1", highs); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        i0.exc_in[i*4 +: 4] = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 2) == 0) ? 4'd1 : 4'($urandom_range(1, 15))) : 4'd0;
        i0.pc_in[i*32 +: 32] = $urandom;
      end
      i0.lock_req_in = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
      i0.resume_in = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random cycle %0d: got %h want %h", n, obs(), expv()); end
      tick();
    end
    rst = 1'b0;
    idle_all();
  endtask
  initial begin
    idle_all();
    m_halt = 0; m_left = 0; m_cause = 0; m_epc = 0; m_src = 0; m_tv = 0;
    @(negedge clk);
    test_reset();
    test_priority();
    test_break();
    test_lock();
    test_mid_flush();
    test_scaling();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
